// File: rtl/bus_fabric_pkg.sv
// Shared bus field layout, ERR_STAT bit positions and watchdog state type for bus_fabric.
package bus_fabric_pkg;

  localparam int unsigned BUS_IN_WIDTH  = 70;
  localparam int unsigned BUS_OUT_WIDTH = 34;

  localparam int unsigned BUS_FIELD_RD_REQ     = 0;
  localparam int unsigned BUS_FIELD_WR_REQ     = 1;
  localparam int unsigned BUS_ADDR_START       = 2;
  localparam int unsigned BUS_ADDR_END         = 33;
  localparam int unsigned BUS_BE_START         = 34;
  localparam int unsigned BUS_BE_END           = 37;
  localparam int unsigned BUS_WR_DATA_START    = 38;
  localparam int unsigned BUS_WR_DATA_END      = 69;
  localparam int unsigned BUS_FIELD_RD_ACK     = 0;
  localparam int unsigned BUS_FIELD_WR_ACK     = 1;
  localparam int unsigned BUS_RD_DATA_START    = 2;
  localparam int unsigned BUS_RD_DATA_END      = 33;

  localparam int unsigned ERR_STAT_VALID       = 0;
  localparam int unsigned ERR_STAT_WAS_WRITE   = 1;
  localparam int unsigned ERR_STAT_COLL        = 2;
  localparam int unsigned ERR_STAT_COUNT_START = 8;
  localparam int unsigned ERR_STAT_COUNT_END   = 15;

  // Field order mirrors the bit positions above (last member is bit 0).
  typedef struct packed {
    logic [31:0] wr_data;
    logic [3:0]  be;
    logic [31:0] addr;
    logic        wr_req;
    logic        rd_req;
  } bus_req_t;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        wr_ack;
    logic        rd_ack;
  } bus_rsp_t;

  typedef enum logic [1:0] {
    WD_IDLE,
    WD_WAIT,
    WD_TERM
  } wd_state_t;

endpackage

// File: rtl/bus_ack_watchdog.sv
// Access watchdog: latches each request and flags a one-cycle termination when no ack
// arrives within TIMEOUT cycles of the request.
module bus_ack_watchdog
  import bus_fabric_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        ack,
  output logic        term,
  output logic        term_write,
  output logic [31:0] term_addr
);

  // Counter reads TIMEOUT-2 in the last WAIT cycle, so TERM lands exactly TIMEOUT after the request.
  localparam logic [15:0] LAST = 16'(TIMEOUT - 2);

  wd_state_t   state, state_next;
  logic [15:0] cnt, cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WD_IDLE;
      cnt        <= '0;
      term_addr  <= '0;
      term_write <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (req) begin
        term_addr  <= req_addr;
        term_write <= req_write;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    term       = 1'b0;
    case (state)
      WD_IDLE: begin
        if (req) begin
          state_next = WD_WAIT;
          cnt_next   = '0;
        end
      end
      WD_WAIT: begin
        if (req) begin
          cnt_next = '0;
        end else if (ack) begin
          state_next = WD_IDLE;
        end else begin
          cnt_next = cnt + 16'd1;
          if (cnt == LAST) state_next = WD_TERM;
        end
      end
      WD_TERM: begin
        term       = ~reset;
        state_next = req ? WD_WAIT : WD_IDLE;
        cnt_next   = '0;
      end
      default: state_next = WD_IDLE;
    endcase
  end

endmodule

// File: rtl/bus_fabric.sv
// Slave return merge with timeout termination, collision detect and ERR_ADDR/ERR_STAT registers.
// Define BUS_FABRIC_OUT_REG_EN to register bus_out (one extra cycle on every ack path).
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned NPORTS   = 8,
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] BUS_ADDR = 32'h0200_0100,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [BUS_IN_WIDTH-1:0]           bus_in,
  input  logic [NPORTS*BUS_OUT_WIDTH-1:0]   slave_bus_out,
  output logic [BUS_OUT_WIDTH-1:0]          bus_out,
  output logic                              err_irq
);

  bus_req_t    req;
  bus_rsp_t    port_rsp, slave_rsp, reg_rsp, term_rsp;
  logic        slave_any, slave_multi, reg_any, term_any, collision;
  logic        hit_addr, hit_stat, clear;
  logic        term, term_write, wd_ack;
  logic [31:0] term_addr, err_addr, stat_word;
  logic        stat_valid, stat_was_write, stat_coll;
  logic [7:0]  stat_count;
  logic [BUS_OUT_WIDTH-1:0] merged;
  logic        unused_bits;

  assign req         = bus_req_t'(bus_in);
  assign unused_bits = ^{req.be[3:1], req.wr_data[31:1]};

  always_comb begin
    slave_rsp   = '0;
    port_rsp    = '0;
    slave_any   = 1'b0;
    slave_multi = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      port_rsp = bus_rsp_t'(slave_bus_out[k*BUS_OUT_WIDTH +: BUS_OUT_WIDTH]);
      if (port_rsp.rd_ack | port_rsp.wr_ack) begin
        slave_multi = slave_multi | slave_any;
        slave_any   = 1'b1;
      end
      slave_rsp = slave_rsp | port_rsp;
    end
  end

  assign reg_any   = reg_rsp.rd_ack | reg_rsp.wr_ack;
  assign term_any  = term_rsp.rd_ack | term_rsp.wr_ack;
  assign collision = slave_multi | (slave_any & reg_any) | (slave_any & term_any) | (reg_any & term_any);

  assign term_rsp.rd_ack  = term & ~term_write;
  assign term_rsp.wr_ack  = term & term_write;
  assign term_rsp.rd_data = (term & ~term_write) ? ERR_DATA : '0;

  assign merged = slave_rsp | reg_rsp | term_rsp;

`ifdef BUS_FABRIC_OUT_REG_EN
  logic [BUS_OUT_WIDTH-1:0] bus_out_q;

  always_ff @(posedge clk) begin
    if (reset) bus_out_q <= '0;
    else       bus_out_q <= merged;
  end

  assign bus_out = bus_out_q;
  assign wd_ack  = bus_out_q[BUS_FIELD_RD_ACK] | bus_out_q[BUS_FIELD_WR_ACK];
`else
  assign bus_out = merged;
  assign wd_ack  = slave_any | reg_any;
`endif

  bus_ack_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .req        (req.rd_req | req.wr_req),
    .req_write  (req.wr_req),
    .req_addr   (req.addr),
    .ack        (wd_ack),
    .term       (term),
    .term_write (term_write),
    .term_addr  (term_addr)
  );

  assign hit_addr  = req.addr[31:2] == BUS_ADDR[31:2];
  assign hit_stat  = req.addr[31:2] == (BUS_ADDR[31:2] + 30'd1);
  assign clear     = req.wr_req & hit_stat & req.be[0] & req.wr_data[0];
  assign stat_word = {16'h0000, stat_count, 5'b00000, stat_coll, stat_was_write, stat_valid};
  assign err_irq   = stat_valid | stat_coll;

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rsp <= '0;
    end else begin
      reg_rsp.rd_ack  <= req.rd_req & (hit_addr | hit_stat);
      reg_rsp.wr_ack  <= req.wr_req & (hit_addr | hit_stat);
      reg_rsp.rd_data <= (req.rd_req & hit_addr) ? err_addr :
                         (req.rd_req & hit_stat) ? stat_word : '0;
    end
  end

  // Later assignments win: a same-cycle capture or collision overrides the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr       <= '0;
      stat_valid     <= 1'b0;
      stat_was_write <= 1'b0;
      stat_coll      <= 1'b0;
      stat_count     <= '0;
    end else begin
      if (clear) begin
        stat_valid <= 1'b0;
        stat_coll  <= 1'b0;
        stat_count <= '0;
      end
      if (collision) stat_coll <= 1'b1;
      if (term) begin
        if (~stat_valid | clear) begin
          err_addr       <= term_addr;
          stat_valid     <= 1'b1;
          stat_was_write <= term_write;
        end
        if (clear)                    stat_count <= 8'd1;
        else if (stat_count != 8'hFF) stat_count <= stat_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboard bench for bus_fabric: expected acks are queued at request time and matched on bus_out.
module tb_bus_fabric;
  import bus_fabric_pkg::*;

  localparam int unsigned NP    = 8;
  localparam int unsigned T     = 64;
  localparam logic [31:0] RADDR = 32'h0200_0100;
  localparam logic [31:0] RSTAT = 32'h0200_0104;
`ifdef BUS_FABRIC_OUT_REG_EN
  localparam int unsigned LAT = 1;
`else
  localparam int unsigned LAT = 0;
`endif

  typedef struct {
    int unsigned cyc;
    logic [1:0]  kind;
    logic [31:0] data;
    string       tag;
  } exp_t;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [BUS_IN_WIDTH-1:0]     bus_in = '0;
  logic [NP*BUS_OUT_WIDTH-1:0] slave_bus_out = '0;
  logic [BUS_OUT_WIDTH-1:0]    bus_out;
  logic                        err_irq;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];

  bus_fabric #(
    .NPORTS   (NP),
    .TIMEOUT  (T),
    .BUS_ADDR (32'h0200_0100),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus_in        (bus_in),
    .slave_bus_out (slave_bus_out),
    .bus_out       (bus_out),
    .err_irq       (err_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard side: every ack on bus_out must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus_out[BUS_FIELD_RD_ACK] | bus_out[BUS_FIELD_WR_ACK]) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", {30'd0, bus_out[1:0]}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_cycle"}, cyc, e.cyc);
        check({e.tag, "_kind"}, {30'd0, bus_out[1:0]}, {30'd0, e.kind});
        check({e.tag, "_data"}, bus_out[BUS_RD_DATA_END:BUS_RD_DATA_START], e.data);
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      check({e.tag, "_missing"}, cyc, e.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus_in        = '0;
    slave_bus_out = '0;
  endtask

  task automatic expect_ack(input int unsigned at, input logic [1:0] kind, input logic [31:0] data,
                            input string tag);
    exp_t e;
    e.cyc  = at;
    e.kind = kind;
    e.data = data;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] be);
    bus_req_t r;
    r         = '0;
    r.rd_req  = ~wr;
    r.wr_req  = wr;
    r.addr    = addr;
    r.be      = be;
    r.wr_data = data;
    bus_in    = r;
  endtask

  task automatic set_slave(input int unsigned k, input logic [31:0] data);
    slave_bus_out[k*BUS_OUT_WIDTH +: BUS_OUT_WIDTH] = {data, 1'b0, 1'b1};
  endtask

  task automatic reg_read(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    issue(1'b0, addr, 32'd0, 4'hF);
    expect_ack(cyc + 1 + LAT, 2'b01, exp, tag);
    repeat (2 + LAT) step();
  endtask

  task automatic reg_write(input logic [31:0] data, input logic [3:0] be, input string tag);
    issue(1'b1, RSTAT, data, be);
    expect_ack(cyc + 1 + LAT, 2'b10, 32'd0, tag);
    repeat (2 + LAT) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned t;
    repeat (3) step();
    check("reset_acks", {30'd0, bus_out[1:0]}, 32'd0);
    check("reset_irq", {31'd0, err_irq}, 32'd0);
    reset = 1'b0;
    step();
    reg_read(RADDR, 32'h0, "reset_err_addr");
    reg_read(RSTAT, 32'h0, "reset_err_stat");

    // Slave 0 answers a read three cycles after the request.
    t = cyc;
    issue(1'b0, 32'h0000_0010, 32'd0, 4'hF);
    expect_ack(t + 3 + LAT, 2'b01, 32'h1234_5678, "slave0_read");
    repeat (3) step();
    set_slave(0, 32'h1234_5678);
    repeat (2 + LAT) step();
    reg_read(RSTAT, 32'h0, "stat_after_slave_read");
    check("irq_after_slave_read", {31'd0, err_irq}, 32'd0);

    // Unmapped read times out.
    t = cyc;
    issue(1'b0, 32'h0500_0000, 32'd0, 4'hF);
    expect_ack(t + T + LAT, 2'b01, 32'hDEAD_BEEF, "timeout_read");
    repeat (T) step();
    check("irq_at_term", {31'd0, err_irq}, 32'd0);
    step();
    check("irq_after_term", {31'd0, err_irq}, 32'd1);
    repeat (LAT + 1) step();
    reg_read(RADDR, 32'h0500_0000, "timeout_err_addr");
    reg_read(RSTAT, 32'h0000_0101, "timeout_err_stat");

    // Clear write landing in a TERM cycle: capture must dominate.
    t = cyc;
    issue(1'b0, 32'h0800_0000, 32'd0, 4'hF);
    expect_ack(t + T + LAT, 2'b01, 32'hDEAD_BEEF, "dominant_timeout");
    repeat (T) step();
    issue(1'b1, RSTAT, 32'h1, 4'h1);
    expect_ack(t + T + 1 + LAT, 2'b10, 32'd0, "dominant_clear");
    repeat (3 + LAT) step();
    reg_read(RSTAT, 32'h0000_0101, "dominant_err_stat");
    do_reset();

    // Two unmapped writes: first address is held, count reaches 2.
    t = cyc;
    issue(1'b1, 32'h0600_0000, 32'h1111_1111, 4'hF);
    expect_ack(t + T + LAT, 2'b10, 32'd0, "timeout_write0");
    repeat (T + LAT + 1) step();
    t = cyc;
    issue(1'b1, 32'h0700_0000, 32'h2222_2222, 4'hF);
    expect_ack(t + T + LAT, 2'b10, 32'd0, "timeout_write1");
    repeat (T + LAT + 1) step();
    reg_read(RADDR, 32'h0600_0000, "two_writes_err_addr");
    reg_read(RSTAT, 32'h0000_0203, "two_writes_err_stat");
    do_reset();

    // Slave 2 acks in the last cycle before termination.
    t = cyc;
    issue(1'b0, 32'h0000_0040, 32'd0, 4'hF);
    expect_ack(t + T - 1, 2'b01, 32'hCAFE_0002, "late_slave_read");
    repeat (T - 1 - LAT) step();
    set_slave(2, 32'hCAFE_0002);
    repeat (LAT + 6) step();
    check("late_slave_irq", {31'd0, err_irq}, 32'd0);
    reg_read(RSTAT, 32'h0, "late_slave_err_stat");

    // Slaves 1 and 3 collide; data is the OR of both.
    t = cyc;
    issue(1'b0, 32'h0000_0020, 32'd0, 4'hF);
    expect_ack(t + 2 + LAT, 2'b01, 32'h0000_0FF0, "collision_read");
    repeat (2) step();
    set_slave(1, 32'h0000_00F0);
    set_slave(3, 32'h0000_0F00);
    step();
    check("collision_irq", {31'd0, err_irq}, 32'd1);
    repeat (LAT) step();
    reg_read(RSTAT, 32'h0000_0004, "collision_err_stat");
    reg_write(32'h1, 4'hE, "clear_no_be0");
    reg_read(RSTAT, 32'h0000_0004, "stat_after_no_be0");
    reg_write(32'h1, 4'h1, "clear_write");
    reg_read(RSTAT, 32'h0, "stat_after_clear");
    check("irq_after_clear", {31'd0, err_irq}, 32'd0);

    // Reset mid-WAIT abandons the access.
    issue(1'b0, 32'h0500_0000, 32'd0, 4'hF);
    repeat (10) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (T + 5) step();
    check("reset_wait_irq", {31'd0, err_irq}, 32'd0);
    reg_read(RADDR, 32'h0, "reset_wait_err_addr");
    reg_read(RSTAT, 32'h0, "reset_wait_err_stat");

    // Reset during the TERM cycle suppresses the ack and the capture.
    issue(1'b1, 32'h0900_0000, 32'd0, 4'hF);
    repeat (T) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    check("reset_term_irq", {31'd0, err_irq}, 32'd0);
    reg_read(RSTAT, 32'h0, "reset_term_err_stat");

    repeat (5) step();
    check("pending_acks", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
